if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 72 +++++++
 tb/tb_if_fetch_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RISC-V IF stage with PC register, synchronous-ROM alignment and the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_IF,
    input  logic        flush_ID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IF,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);
    typedef enum logic {BOOT, RUN} state_t;
    state_t state, state_nx;
    logic [31:0] pc_nx, id_pc_nx, id_instr_nx, count_nx, target;
    logic id_valid_nx;
    assign target = {redirect_pc[31:2], 2'b00};
    // The ROM is addressed with the PC it will hold next, so its data lines up with PC_IF one edge later.
    assign imem_addr = rstn ? pc_nx : RESET_PC;
    always_comb begin
        state_nx    = RUN;
        pc_nx       = PC_IF;
        id_pc_nx    = '0;
        id_instr_nx = NOP_INSTR;
        id_valid_nx = 1'b0;
        count_nx    = fetch_count;
        if (redirect_valid) begin
            pc_nx = target;
        end else if (state == RUN && stall_IF) begin
            if (!flush_ID) begin
                id_pc_nx    = if_id_pc;
                id_instr_nx = if_id_instr;
                id_valid_nx = if_id_valid;
            end
        end else if (state == RUN) begin
            pc_nx = PC_IF + 32'd4;
            if (!flush_ID) begin
                id_pc_nx    = PC_IF;
                id_instr_nx = imem_rdata;
                id_valid_nx = 1'b1;
                count_nx    = fetch_count + 32'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= BOOT;
            PC_IF        <= RESET_PC;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            fetch_count  <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nx;
            PC_IF        <= pc_nx;
            if_id_pc     <= id_pc_nx;
            if_id_instr  <= id_instr_nx;
            if_id_valid  <= id_valid_nx;
            fetch_count  <= count_nx;
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: vector table plus delivery scoreboard for if_fetch_stage against a ROM[i]=i+0x100 model.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0, rstn = 1'b0, stall_IF = 1'b0, flush_ID = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic [31:0] imem_addr, PC_IF, if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid, misalign_err;
    int total = 0, bad = 0;

    typedef struct {
        logic        stall, flush, rv;
        logic [31:0] rpc, pc_if;
        logic        valid;
        logic [31:0] id_pc, cnt;
        logic        mis;
    } vec_t;
    vec_t tbl[23];
    logic [63:0] sb[$];

    if_fetch_stage dut (
        .clk(clk), .rstn(rstn), .stall_IF(stall_IF), .flush_ID(flush_ID),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .PC_IF(PC_IF), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    always @(posedge clk) imem_rdata <= rom(imem_addr);

    function automatic vec_t mk(input logic s, f, rv, input logic [31:0] rpc, pc,
                                input logic val, input logic [31:0] idpc, cnt, input logic mis);
        vec_t r;
        r.stall = s; r.flush = f; r.rv = rv; r.rpc = rpc; r.pc_if = pc;
        r.valid = val; r.id_pc = idpc; r.cnt = cnt; r.mis = mis;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_cnt, dut_cnt;
        logic [63:0] e;
        tbl[0]  = mk(0, 0, 0, 0,            32'h0,        0, 32'h0,        0,  0);
        tbl[1]  = mk(0, 0, 0, 0,            32'h4,        1, 32'h0,        1,  0);
        tbl[2]  = mk(0, 0, 0, 0,            32'h8,        1, 32'h4,        2,  0);
        tbl[3]  = mk(0, 0, 0, 0,            32'hC,        1, 32'h8,        3,  0);
        tbl[4]  = mk(0, 0, 0, 0,            32'h10,       1, 32'hC,        4,  0);
        tbl[5]  = mk(1, 0, 0, 0,            32'h10,       1, 32'hC,        4,  0);
        tbl[6]  = mk(1, 0, 0, 0,            32'h10,       1, 32'hC,        4,  0);
        tbl[7]  = mk(1, 0, 0, 0,            32'h10,       1, 32'hC,        4,  0);
        tbl[8]  = mk(0, 0, 0, 0,            32'h14,       1, 32'h10,       5,  0);
        tbl[9]  = mk(1, 0, 1, 32'h40,       32'h40,       0, 32'h0,        5,  0);
        tbl[10] = mk(0, 0, 0, 0,            32'h44,       1, 32'h40,       6,  0);
        tbl[11] = mk(0, 0, 1, 32'h42,       32'h40,       0, 32'h0,        6,  1);
        tbl[12] = mk(0, 0, 0, 0,            32'h44,       1, 32'h40,       7,  0);
        tbl[13] = mk(1, 1, 0, 0,            32'h44,       0, 32'h0,        7,  0);
        tbl[14] = mk(0, 1, 0, 0,            32'h48,       0, 32'h0,        7,  0);
        tbl[15] = mk(0, 0, 0, 0,            32'h4C,       1, 32'h48,       8,  0);
        tbl[16] = mk(0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 32'h0,      8,  0);
        tbl[17] = mk(0, 0, 0, 0,            32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 9, 0);
        tbl[18] = mk(0, 0, 0, 0,            32'h0,        1, 32'hFFFF_FFFC, 10, 0);
        tbl[19] = mk(0, 0, 0, 0,            32'h4,        1, 32'h0,        11, 0);
        tbl[20] = mk(0, 0, 1, 32'h80,       32'h80,       0, 32'h0,        11, 0);
        tbl[21] = mk(0, 0, 0, 0,            32'h84,       1, 32'h80,       12, 0);
        tbl[22] = mk(0, 0, 1, 32'h80,       32'h80,       0, 32'h0,        12, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc_if", PC_IF, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check("rst_instr", if_id_instr, NOP);
        check("rst_cnt", fetch_count, 32'h0);

        exp_cnt = 0;
        dut_cnt = 0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            rstn = 1'b1;
            stall_IF = tbl[i].stall;
            flush_ID = tbl[i].flush;
            redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc;
            if (tbl[i].cnt != exp_cnt) sb.push_back({tbl[i].id_pc, rom(tbl[i].id_pc)});
            exp_cnt = tbl[i].cnt;
            @(posedge clk);
            #1;
            check($sformatf("pc_if[%0d]", i), PC_IF, tbl[i].pc_if);
            check($sformatf("valid[%0d]", i), {31'b0, if_id_valid}, {31'b0, tbl[i].valid});
            check($sformatf("id_pc[%0d]", i), if_id_pc, tbl[i].id_pc);
            check($sformatf("id_instr[%0d]", i), if_id_instr, tbl[i].valid ? rom(tbl[i].id_pc) : NOP);
            check($sformatf("cnt[%0d]", i), fetch_count, tbl[i].cnt);
            check($sformatf("mis[%0d]", i), {31'b0, misalign_err}, {31'b0, tbl[i].mis});
            if (tbl[i].stall && !tbl[i].rv) check($sformatf("stall_addr[%0d]", i), imem_addr, tbl[i].pc_if);
            if (fetch_count != dut_cnt) begin
                if (sb.size() == 0) begin
                    check($sformatf("sb_unexpected[%0d]", i), fetch_count, dut_cnt);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("sb_pc[%0d]", i), if_id_pc, e[63:32]);
                    check($sformatf("sb_instr[%0d]", i), if_id_instr, e[31:0]);
                end
            end
            dut_cnt = fetch_count;
        end
        check("sb_leftover", sb.size(), 0);

        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h44;
        #2 rstn = 1'b0;
        #1;
        check("arst_pc_if", PC_IF, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", {31'b0, if_id_valid}, 32'h0);
        check("arst_id_pc", if_id_pc, 32'h0);
        check("arst_instr", if_id_instr, NOP);
        check("arst_cnt", fetch_count, 32'h0);
        check("arst_mis", {31'b0, misalign_err}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("boot_pc_if", PC_IF, 32'h0);
        check("boot_valid", {31'b0, if_id_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("first_valid", {31'b0, if_id_valid}, 32'h1);
        check("first_pc", if_id_pc, 32'h0);
        check("first_instr", if_id_instr, 32'h100);
        check("first_cnt", fetch_count, 32'h1);
        check("first_pc_if", PC_IF, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
